// File: rtl/uart_xmtr.sv
// Byte-FIFO fed UART transmitter producing 8N1 frames on uart_sout.
// Define UART_XMTR_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_xmtr #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_sout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_XMTR_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_sout;
`ifdef UART_XMTR_PARITY_EN
  logic             r_parity;
`endif

  logic       w_push;
  logic       w_pop;
  logic       w_baud_done;
  logic       w_fifo_empty;
  logic [7:0] w_head;

  assign w_fifo_empty = (r_count == '0);
  assign w_baud_done  = (r_baud == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_push       = tx_valid && tx_ready;
  // The head is taken when idle, or at the last cycle of a stop bit so frames abut.
  assign w_pop        = !w_fifo_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));

  assign tx_ready   = (r_count != FIFO_FULL);
  assign busy       = (r_state != S_IDLE) || !w_fifo_empty;
  assign fifo_count = r_count;
  assign uart_sout  = r_sout;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_sout    <= 1'b1;
`ifdef UART_XMTR_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sout <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
`ifdef UART_XMTR_PARITY_EN
            r_parity <= ^w_head;
`endif
            r_baud  <= BAUD_LOAD;
            r_state <= S_START;
            r_sout  <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= BAUD_LOAD;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_sout    <= r_shift[0];
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= BAUD_LOAD;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_XMTR_PARITY_EN
              r_state <= S_PARITY;
              r_sout  <= r_parity;
`else
              r_state <= S_STOP;
              r_sout  <= 1'b1;
`endif
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              r_sout    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
`ifdef UART_XMTR_PARITY_EN
        S_PARITY: begin
          if (w_baud_done) begin
            r_baud  <= BAUD_LOAD;
            r_state <= S_STOP;
            r_sout  <= 1'b1;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_baud_done) begin
            if (w_pop) begin
              r_shift <= w_head;
`ifdef UART_XMTR_PARITY_EN
              r_parity <= ^w_head;
`endif
              r_baud  <= BAUD_LOAD;
              r_state <= S_START;
              r_sout  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_sout  <= 1'b1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_sout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xmtr.sv
// Directed bench for uart_xmtr: one instance at 16 clocks/bit, one at 3 clocks/bit,
// with a serial receiver model decoding both lines.
module tb_uart_xmtr;

  localparam int CPB_A = 16;
  localparam int CPB_B = 3;
`ifdef UART_XMTR_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_A = FB * CPB_A;

  logic       clock;
  logic       rst_a_n, rst_b_n;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       sout_a, sout_b;
  logic       busy_a, busy_b;
  logic [4:0] count_a, count_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_xmtr #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(16)) dut_a (
    .clock(clock), .reset_n(rst_a_n), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .uart_sout(sout_a), .busy(busy_a), .fifo_count(count_a)
  );

  uart_xmtr #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(16)) dut_b (
    .clock(clock), .reset_n(rst_b_n), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .uart_sout(sout_b), .busy(busy_b), .fifo_count(count_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Receiver model: samples each bit mid-period, flags bad start/stop/parity.
  bit          m_act [2];
  int          m_phase [2];
  logic [10:0] m_sh [2];
  int          m_err [2];
  logic [7:0]  rx_q0 [$];
  logic [7:0]  rx_q1 [$];
  int          start_q0 [$];
  logic        mon_ln, mon_rs;
  int          mon_cp, mon_j;
  logic [10:0] mon_frame;

  initial begin
    m_act = '{0, 0};
    m_phase = '{0, 0};
    m_err = '{0, 0};
    forever begin
      @(negedge clock);
      for (int m = 0; m < 2; m++) begin
        mon_ln = (m == 0) ? sout_a : sout_b;
        mon_rs = (m == 0) ? rst_a_n : rst_b_n;
        mon_cp = (m == 0) ? CPB_A : CPB_B;
        if (mon_rs !== 1'b1) begin
          m_act[m] = 0;
        end else begin
          if (!m_act[m] && mon_ln === 1'b0) begin
            m_act[m] = 1;
            m_phase[m] = 0;
            if (m == 0) start_q0.push_back(cyc);
          end
          if (m_act[m]) begin
            if (m_phase[m] % mon_cp == mon_cp / 2) begin
              mon_j = m_phase[m] / mon_cp;
              m_sh[m][mon_j] = mon_ln;
              if (mon_j == FB - 1) begin
                mon_frame = m_sh[m];
                if (mon_frame[0] !== 1'b0 || mon_frame[FB-1] !== 1'b1) m_err[m]++;
`ifdef UART_XMTR_PARITY_EN
                if (mon_frame[9] !== ^mon_frame[8:1]) m_err[m]++;
`endif
                if (m == 0) rx_q0.push_back(mon_frame[8:1]);
                else        rx_q1.push_back(mon_frame[8:1]);
                $display("rx%0d cycle=%0d byte=%02h", m, cyc, mon_frame[8:1]);
                m_act[m] = 0;
              end
            end
            m_phase[m]++;
          end
        end
      end
    end
  end

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a !== 1'b0 && n < 3 * FRAME_A) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle_a: busy=%b required 0", busy_a);
    end
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00;
    repeat (3) @(negedge clock);
    checks += 5;
    if (sout_a !== 1'b1)   begin errors++; $display("FAIL reset_sout: got %b want 1", sout_a); end
    if (ready_a !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b want 1", ready_a); end
    if (busy_a !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    if (count_a !== 5'd0)  begin errors++; $display("FAIL reset_count: got %0d want 0", count_a); end
    if (sout_b !== 1'b1)   begin errors++; $display("FAIL reset_sout_b: got %b want 1", sout_b); end
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    $display("test_reset done");
  endtask

  // Exact line waveform of one frame, checked every cycle.
  task automatic test_single_frame(input logic [7:0] byte_in, input logic [10:0] exp_frame);
    logic exp_bit;
    wait_idle_a();
    @(negedge clock);
    data_a = byte_in; valid_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid_a = 1'b0;
    checks += 3;
    if (count_a !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count_a); end
    if (sout_a !== 1'b1)  begin errors++; $display("FAIL single_idle_line: got %b want 1", sout_a); end
    if (busy_a !== 1'b1)  begin errors++; $display("FAIL single_busy: got %b want 1", busy_a); end
    for (int k = 1; k <= FRAME_A; k++) begin
      @(posedge clock);
      @(negedge clock);
      exp_bit = exp_frame[(k-1)/CPB_A];
      checks++;
      if (sout_a !== exp_bit) begin
        errors++;
        $display("FAIL frame_%02h cycle %0d: line=%b want %b", byte_in, k, sout_a, exp_bit);
      end
    end
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_last_stop: got %b want 1", busy_a); end
    @(posedge clock);
    @(negedge clock);
    checks += 2;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_after_frame: got %b want 0", busy_a); end
    if (sout_a !== 1'b1) begin errors++; $display("FAIL line_after_frame: got %b want 1", sout_a); end
    $display("test_single_frame byte=%02h done", byte_in);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    wait_idle_a();
    rx_q0.delete(); start_q0.delete();
    @(negedge clock);
    data_a = 8'h41; valid_a = 1'b1;
    @(negedge clock);
    data_a = 8'h0A;
    @(negedge clock);
    valid_a = 1'b0;
    while (rx_q0.size() < 2 && n < 2 * FRAME_A + 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (rx_q0.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d bytes want 2", rx_q0.size());
    end else begin
      checks += 3;
      if (rx_q0[0] !== 8'h41) begin errors++; $display("FAIL b2b_byte0: got %02h want 41", rx_q0[0]); end
      if (rx_q0[1] !== 8'h0A) begin errors++; $display("FAIL b2b_byte1: got %02h want 0a", rx_q0[1]); end
      if (start_q0[1] - start_q0[0] != FRAME_A) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d want %0d", start_q0[1] - start_q0[0], FRAME_A);
      end
    end
    $display("test_back_to_back done");
  endtask

  // 18 bytes offered continuously: 17 fit (one pops immediately), the 18th waits
  // until the first frame's stop bit finishes.
  task automatic test_fifo_full();
    int acc [18];
    int idx = 0;
    int n = 0;
    logic rdy;
    wait_idle_a();
    rx_q0.delete(); start_q0.delete();
    @(negedge clock);
    for (int t = 0; t < FRAME_A + 20 && idx < 18; t++) begin
      data_a = 8'hA0 + 8'(idx); valid_a = 1'b1;
      rdy = ready_a;
      @(posedge clock);
      if (rdy) begin acc[idx] = t; idx++; end
      @(negedge clock);
      if (t == 1) begin
        checks++;
        if (count_a !== 5'd1) begin errors++; $display("FAIL full_first_pop: count=%0d want 1", count_a); end
      end
      if (t == 16) begin
        checks += 2;
        if (count_a !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", count_a); end
        if (ready_a !== 1'b0)  begin errors++; $display("FAIL full_ready: got %b want 0", ready_a); end
      end
      if (t == FRAME_A + 1) begin
        checks += 2;
        if (ready_a !== 1'b1)  begin errors++; $display("FAIL full_reopen: got %b want 1", ready_a); end
        if (count_a !== 5'd15) begin errors++; $display("FAIL full_reopen_count: got %0d want 15", count_a); end
      end
    end
    valid_a = 1'b0;
    checks++;
    if (idx != 18) begin
      errors++;
      $display("FAIL full_accept_all: got %0d want 18", idx);
    end else begin
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (acc[i] != ((i < 17) ? i : FRAME_A + 2)) begin
          errors++;
          $display("FAIL full_accept_edge[%0d]: got %0d want %0d", i, acc[i], (i < 17) ? i : FRAME_A + 2);
        end
      end
    end
    while (rx_q0.size() < 18 && n < 18 * FRAME_A + 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (rx_q0.size() != 18) begin
      errors++;
      $display("FAIL full_rx_count: got %0d want 18", rx_q0.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (rx_q0[i] !== 8'hA0 + 8'(i)) begin
          errors++;
          $display("FAIL full_rx[%0d]: got %02h want %02h", i, rx_q0[i], 8'hA0 + 8'(i));
        end
      end
    end
    checks++;
    if (m_err[0] != 0) begin errors++; $display("FAIL full_framing: got %0d errors want 0", m_err[0]); end
    $display("test_fifo_full done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] bytes [4];
    bit saw_low = 0;
    bytes = '{8'hF0, 8'h11, 8'h22, 8'h33};
    wait_idle_a();
    rx_q0.delete(); start_q0.delete();
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      data_a = bytes[i]; valid_a = 1'b1;
      @(negedge clock);
    end
    valid_a = 1'b0;
    // Pop was one edge after the first push; land inside data bit 1 (a 0 of 0xF0).
    repeat (37) @(negedge clock);
    checks += 2;
    if (sout_a !== 1'b0)  begin errors++; $display("FAIL mid_line_before: got %b want 0", sout_a); end
    if (count_a !== 5'd3) begin errors++; $display("FAIL mid_count_before: got %0d want 3", count_a); end
    rst_a_n = 1'b0;
    #1;
    checks += 4;
    if (sout_a !== 1'b1)  begin errors++; $display("FAIL mid_reset_line: got %b want 1", sout_a); end
    if (count_a !== 5'd0) begin errors++; $display("FAIL mid_reset_count: got %0d want 0", count_a); end
    if (ready_a !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", ready_a); end
    if (busy_a !== 1'b0)  begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy_a); end
    repeat (2) @(negedge clock);
    rst_a_n = 1'b1;
    rx_q0.delete();
    for (int k = 0; k < 3 * FRAME_A; k++) begin
      @(negedge clock);
      if (sout_a !== 1'b1) saw_low = 1;
    end
    checks += 3;
    if (saw_low)             begin errors++; $display("FAIL mid_no_frame_line: got low want high"); end
    if (rx_q0.size() != 0)   begin errors++; $display("FAIL mid_no_frame_rx: got %0d bytes want 0", rx_q0.size()); end
    if (busy_a !== 1'b0)     begin errors++; $display("FAIL mid_busy_after: got %b want 0", busy_a); end
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_random_cpb3();
    logic [7:0] exp_b [64];
    int idx = 0;
    int n = 0;
    logic go;
    for (int i = 0; i < 64; i++) exp_b[i] = 8'($urandom_range(0, 255));
    rx_q1.delete();
    @(negedge clock);
    while (idx < 64 && n < 8000) begin
      go = ($urandom_range(0, 3) != 0);
      valid_b = go;
      data_b = exp_b[idx];
      go = go && ready_b;
      @(posedge clock);
      if (go) idx++;
      @(negedge clock);
      n++;
    end
    valid_b = 1'b0;
    checks++;
    if (idx != 64) begin errors++; $display("FAIL rand_accept: got %0d want 64", idx); end
    n = 0;
    while (rx_q1.size() < 64 && n < 64 * FB * CPB_B + 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (rx_q1.size() != 64) begin
      errors++;
      $display("FAIL rand_rx_count: got %0d want 64", rx_q1.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (rx_q1[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL rand_rx[%0d]: got %02h want %02h", i, rx_q1[i], exp_b[i]);
        end
      end
    end
    checks++;
    if (m_err[1] != 0) begin errors++; $display("FAIL rand_framing: got %0d errors want 0", m_err[1]); end
    $display("test_random_cpb3 done");
  endtask

  initial begin
    logic [10:0] f55;
`ifdef UART_XMTR_PARITY_EN
    logic [10:0] f07;
    f55 = {1'b1, 1'b0, 8'h55, 1'b0};
    f07 = {1'b1, 1'b1, 8'h07, 1'b0};
`else
    f55 = {2'b11, 8'h55, 1'b0};
`endif
    test_reset();
    test_single_frame(8'h55, f55);
`ifdef UART_XMTR_PARITY_EN
    test_single_frame(8'h07, f07);
`endif
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_random_cpb3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
